hazard_sequencer: RTL and testbench

Pipeline hazard and multi-cycle scheduling controller for the five-stage RV32IM core. It drives the stall and flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers from three hazard sources:
- taken branches and jumps, resolved in MEM;
- load-use dependences;
- iterative DIV/DIVU/REM/REMU operations occupying EX.

It also keeps saturating stall and flush counters for performance evaluation.

---
 rtl/hazard_sequencer_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_sequencer.sv | 121 ++++++++++++
 tb/tb_hazard_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: divider FSM states and core constants.
package hazard_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_CYCLES_DEFAULT = 32;
   localparam int REG_IDX_W          = 5;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the five-stage core: taken control transfers,
// load-use hazards and the iterative divider, plus saturating perf counters.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] rs1D,
   input  logic [REG_IDX_W-1:0] rs2D,
   input  logic [REG_IDX_W-1:0] rdE,
   input  logic                 MemtoRegE,
   input  logic                 divE,
   input  logic                 BranchM,
   input  logic                 zeroM,
   input  logic                 JumpM,
   output logic                 stallF,
   output logic                 stallD,
   output logic                 stallE,
   output logic                 flushD,
   output logic                 flushE,
   output logic                 flushM,
   output logic                 pcsrcM,
   output logic                 div_start,
   output logic                 div_abort,
   output logic                 div_valid,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int CW = $clog2(DIV_CYCLES);

   div_state_t    state;
   logic [CW-1:0] cnt;
   logic          takenM;
   logic          lduse;
   logic          div_hold;

   assign takenM   = (BranchM & zeroM) | JumpM;
   assign lduse    = MemtoRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign div_hold = ((state == IDLE) && divE) || (state == BUSY);

   // cnt holds the BUSY cycles still to run; leaving on cnt == 1 gives DIV_CYCLES-1 BUSY cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (divE && !takenM) begin
                  state <= BUSY;
                  cnt   <= CW'(DIV_CYCLES - 1);
               end
            end
            BUSY: begin
               if (takenM) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      pcsrcM    = 1'b0;
      div_start = 1'b0;
      div_abort = 1'b0;
      div_valid = 1'b0;
      if (!reset) begin
         div_valid = (state == DONE);
         if (takenM) begin
            pcsrcM    = 1'b1;
            flushD    = 1'b1;
            flushE    = 1'b1;
            flushM    = 1'b1;
            div_abort = (state == BUSY);
         end else if (div_hold) begin
            stallF    = 1'b1;
            stallD    = 1'b1;
            stallE    = 1'b1;
            flushM    = 1'b1;
            div_start = (state == IDLE);
         end else if (lduse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stallF),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (takenM),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Two sequencer instances (DIV_CYCLES 4 / 32-bit counters, DIV_CYCLES 5 / 4-bit counters)
// share one stimulus stream and are checked every cycle against an occupancy-age model.
module tb_hazard_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
   logic       MemtoRegE = 1'b0, divE = 1'b0, BranchM = 1'b0, zeroM = 1'b0, JumpM = 1'b0;

   logic        a_stallF, a_stallD, a_stallE, a_flushD, a_flushE, a_flushM, a_pcsrcM;
   logic        a_start, a_abort, a_valid;
   logic [31:0] a_scnt, a_fcnt;
   logic        b_stallF, b_stallD, b_stallE, b_flushD, b_flushE, b_flushM, b_pcsrcM;
   logic        b_start, b_abort, b_valid;
   logic [3:0]  b_scnt, b_fcnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_sequencer #(.DIV_CYCLES(4), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .MemtoRegE(MemtoRegE), .divE(divE), .BranchM(BranchM), .zeroM(zeroM), .JumpM(JumpM),
      .stallF(a_stallF), .stallD(a_stallD), .stallE(a_stallE), .flushD(a_flushD),
      .flushE(a_flushE), .flushM(a_flushM), .pcsrcM(a_pcsrcM), .div_start(a_start),
      .div_abort(a_abort), .div_valid(a_valid), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
   );

   hazard_sequencer #(.DIV_CYCLES(5), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .MemtoRegE(MemtoRegE), .divE(divE), .BranchM(BranchM), .zeroM(zeroM), .JumpM(JumpM),
      .stallF(b_stallF), .stallD(b_stallD), .stallE(b_stallE), .flushD(b_flushD),
      .flushE(b_flushE), .flushM(b_flushM), .pcsrcM(b_pcsrcM), .div_start(b_start),
      .div_abort(b_abort), .div_valid(b_valid), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
   );

   // {pcsrcM, flushD, flushE, flushM, stallF, stallD, stallE, div_start, div_abort, div_valid}
   wire [9:0] outs_a = {a_pcsrcM, a_flushD, a_flushE, a_flushM, a_stallF, a_stallD, a_stallE,
                        a_start, a_abort, a_valid};
   wire [9:0] outs_b = {b_pcsrcM, b_flushD, b_flushE, b_flushM, b_stallF, b_stallD, b_stallE,
                        b_start, b_abort, b_valid};

   // age = cycles since div_start (0 = no divide in progress); DONE is age == DIV_CYCLES
   int        age  [2];
   longint    scnt [2];
   longint    fcnt [2];
   int        dcyc [2] = '{4, 5};
   longint    cmax [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
   logic [9:0] last_a;

   function automatic logic [9:0] model_outs(int i);
      logic tk, ld, idle, busy, done, hold;
      logic [9:0] r;
      tk   = (BranchM & zeroM) | JumpM;
      ld   = MemtoRegE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      idle = (age[i] == 0);
      busy = (age[i] >= 1) && (age[i] <= dcyc[i] - 1);
      done = (age[i] == dcyc[i]);
      hold = (idle && divE) || busy;
      r = '0;
      if (reset) return r;
      r[0] = done;
      if (tk) begin
         r[9:6] = 4'b1111;
         r[1]   = busy;
      end else if (hold) begin
         r[6:3] = 4'b1111;
         r[2]   = idle;
      end else if (ld) begin
         r[7] = 1'b1;
         r[5] = 1'b1;
         r[4] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         age[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end
   endtask

   task automatic model_advance(int i);
      logic [9:0] e;
      logic tk;
      e  = model_outs(i);
      tk = (BranchM & zeroM) | JumpM;
      if (e[5] && scnt[i] < cmax[i]) scnt[i]++;
      if (tk && fcnt[i] < cmax[i]) fcnt[i]++;
      if (age[i] == 0) begin
         if (divE && !tk) age[i] = 1;
      end else if (age[i] < dcyc[i]) begin
         age[i] = tk ? 0 : age[i] + 1;
      end else begin
         age[i] = 0;
      end
   endtask

   task automatic check(string name, longint got, longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Called just after a falling edge with inputs settled; returns just after the next one.
   task automatic step();
      #1;
      if (reset) model_clear();
      check("outs_a", outs_a, model_outs(0));
      check("outs_b", outs_b, model_outs(1));
      check("stall_cnt_a", a_scnt, scnt[0]);
      check("flush_cnt_a", a_fcnt, fcnt[0]);
      check("stall_cnt_b", b_scnt, scnt[1]);
      check("flush_cnt_b", b_fcnt, fcnt[1]);
      last_a = outs_a;
      @(posedge clk);
      if (reset) model_clear();
      else begin
         model_advance(0);
         model_advance(1);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic dv, input logic b,
                        input logic z, input logic j);
      MemtoRegE = mr; rdE = rd; rs1D = r1; rs2D = r2;
      divE = dv; BranchM = b; zeroM = z; JumpM = j;
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      #1;
      check("reset_outs", outs_a, 0);
      check("reset_stall_cnt", a_scnt, 0);
      check("reset_flush_cnt", a_fcnt, 0);
      @(negedge clk);
      reset = 1'b0;

      // load-use, then a load to x0
      drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
      step();
      check("lduse_outs", last_a, 10'b0010110000);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("lduse_one_cycle", last_a, 0);
      check("lduse_stall_cnt", a_scnt, 1);
      drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      step();
      check("lduse_x0", last_a, 0);

      // full divide, DIV_CYCLES = 4
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0)      check("div_c0", last_a, 10'b0001111100);
         else if (k < 4)  check("div_busy", last_a, 10'b0001111000);
         else             check("div_done", last_a, 10'b0000000001);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("div_stall_cnt", a_scnt, 5);

      // taken branch, then not-taken
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      step();
      check("taken_outs", last_a, 10'b1111000000);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      step();
      check("not_taken_outs", last_a, 0);
      check("taken_flush_cnt", a_fcnt, 1);

      // jump on cycle 2 of a divide
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      step();
      step();
      drive(0, 0, 0, 0, 1, 0, 0, 1);
      step();
      check("abort_outs", last_a, 10'b1111000010);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("after_abort_idle", last_a, 0);
      end

      // asynchronous reset on cycle 2 of a divide
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst_mid_outs", outs_a, 0);
      check("rst_mid_stall_cnt", a_scnt, 0);
      check("rst_mid_flush_cnt", a_fcnt, 0);
      step();
      reset = 1'b0;
      step();
      check("restart_after_reset", last_a, 10'b0001111100);

      // 20 back-to-back stall cycles: 4-bit counter must stick at 15
      drive(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (20) step();
      check("sat_stall_cnt_b", b_scnt, 15);
      check("stall_cnt_a_20", a_scnt, 20);

      // randomized traffic with occasional mid-cycle resets
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 99) == 0);
         divE      = ($urandom_range(0, 3) == 0);
         MemtoRegE = !divE && ($urandom_range(0, 2) == 0);
         rdE       = 5'($urandom_range(0, 3));
         rs1D      = 5'($urandom_range(0, 3));
         rs2D      = 5'($urandom_range(0, 3));
         BranchM   = ($urandom_range(0, 4) == 0);
         zeroM     = 1'($urandom_range(0, 1));
         JumpM     = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
